pet2001_tap_player: RTL
=======================

// Module: pet2001_tap_player
// PURPOSE
//  Cassette #1 emulator at the far end of the PET datasette interface: replays a TAP
//  pulse stream into the I/O block's cass_read/cass_sense_n inputs, gated by cass_motor_n.
//  Host/SD loader pushes TAP payload bytes (header stripped) through a valid/ready port;
//  an internal FIFO decouples loader latency from 1 MHz (ce) pulse timing.
// PARAMETERS
//  FIFO_DEPTH  16  byte FIFO entries, power of two >= 4
//  CNT_W       24  pulse-length counter width (cycles of ce)
// PORTS
//  clk           in   1  system clock
//  reset_n       in   1  synchronous reset, active low
//  ce            in   1  1 MHz CPU clock enable; all pulse timing counts ce ticks
//  play          in   1  PLAY key held; low flushes and idles the player
//  tap_version   in   1  TAP format version (0 or 1), sampled while IDLE
//  tap_data      in   8  TAP payload byte
//  tap_valid     in   1  tap_data valid
//  tap_ready     out  1  FIFO accepts byte; transfer on clk when valid&&ready
//  cass_motor_n  in   1  motor control from PIA1 CB2, low = motor on
//  cass_read     out  1  tape read signal to PIA1 (CA1 sees !cass_read)
//  cass_sense_n  out  1  = !play, registered
//  underrun      out  1  sticky: FIFO empty when a byte was needed mid-play
// BEHAVIOUR
//  Reset: cass_read=0, cass_sense_n=1, tap_ready=0, underrun=0, FIFO empty, state IDLE.
//  tap_ready = !fifo_full && play (registered-free); byte accepted same clk, visible to
//   FETCH next clk. Simultaneous push+pop on full/empty FIFO legal, count unchanged.
//  States: IDLE, FETCH, EXT0, EXT1, EXT2, HIGH, LOW.
//   IDLE : play=1 -> FETCH. play=0 anywhere -> IDLE next clk, FIFO flushed, cass_read=0,
//          underrun cleared.
//   FETCH: on ce && !cass_motor_n && FIFO non-empty, pop byte b:
//          b!=0 -> N=b*8 -> HIGH; b==0 && v0 -> N=2048 -> HIGH; b==0 && v1 -> EXT0.
//          FIFO empty on that ce tick -> underrun<=1, stay FETCH (cass_read held).
//   EXT0/1/2: pop next bytes as N[7:0], N[15:8], N[23:16] (little endian), same pop and
//          underrun rules as FETCH; after EXT2 -> HIGH. N==0 or 1 forced to 2.
//   HIGH : cass_read=1 for N>>1 ce ticks, then LOW.
//   LOW  : cass_read=0 for N-(N>>1) ce ticks, then FETCH.
//  Period of each pulse = exactly N ce ticks from rising edge to next rising edge
//   provided next byte present (FETCH pop occurs on the ce tick ending LOW: zero gap).
//  Motor off (cass_motor_n=1): counter and state frozen, cass_read holds level; resumes
//   on the first ce tick with motor on. FIFO still fills.
//  Arithmetic: b*8 zero-extended to CNT_W; counter decrements on ce only.
//  cass_sense_n registered from play, one clk latency.
// CONFIGURATION
//  PET2001_TAP_V1_EN defined: version-1 long pulses via EXT0..EXT2 as above.
//  Not defined: EXT states omitted, tap_version ignored, zero byte always N=2048.
// STRUCTURE
//  pet2001_tap_pkg: state enum, PULSE_UNIT=8, V0_OVERFLOW=2048, MIN_PULSE=2.
//  Sub-module pet2001_tap_fifo (sync FIFO, flush input, full/empty flags); player FSM
//   and counter in this module.
// TESTING
//  1 play=1, motor on, push 0x30 -> cass_read high 192 ce ticks, low 192, period 384.
//  2 v1, push 00 10 27 00 (N=10000) -> high 5000 ce, low 5000; without macro: 2048 then
//    0x10 pulse (128) etc.
//  3 mid-HIGH drive cass_motor_n=1 for 500 ce -> cass_read frozen, pulse stretched by 500.
//  4 FIFO empty after one pulse -> underrun=1, cass_read stays 0; push 0x20 -> resumes.
//  5 fill 16 bytes -> tap_ready=0; play=0 -> IDLE next clk, FIFO empty, sense_n=1.
//  6 reset_n=0 mid-LOW -> all outputs to reset values next clk, play re-start clean.

Source files
------------

// File: rtl/pet2001_tap_pkg.sv
// Shared types and constants for the PET 2001 TAP cassette player.
// Optional macro PET2001_TAP_V1_EN enables version-1 long pulses in the player.
package pet2001_tap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXT0,
        ST_EXT1,
        ST_EXT2,
        ST_HIGH,
        ST_LOW
    } tap_state_e;

    localparam int PULSE_UNIT  = 8;
    localparam int V0_OVERFLOW = 2048;
    localparam int MIN_PULSE   = 2;

    // A zero or one-tick pulse cannot be split into a high and a low phase.
    function automatic logic [23:0] clamp_pulse(input logic [23:0] n);
        return (n < 24'(MIN_PULSE)) ? 24'(MIN_PULSE) : n;
    endfunction

endpackage

// File: rtl/pet2001_tap_player_if.sv
// Byte stream port from the host/SD loader into the TAP player FIFO.
interface pet2001_tap_player_if;
    logic [7:0] tap_data;
    logic       tap_valid;
    logic       tap_ready;

    modport master (output tap_data, output tap_valid, input tap_ready);
    modport slave  (input tap_data, input tap_valid, output tap_ready);
endinterface

// File: rtl/pet2001_tap_fifo.sv
// Synchronous byte FIFO with flush; head byte is readable combinationally.
module pet2001_tap_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [DEPTH-1:0][7:0]   mem_q, mem_d;
    logic                    wr_en;
    logic                    rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rd_en = pop && !empty;
    // A pop on the same clock frees the slot, so a full FIFO can still take a byte.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem_q[rd_ptr_q];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            assign mem_d[gi] = (wr_en && (wr_ptr_q == AW'(gi))) ? din : mem_q[gi];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pet2001_tap_player.sv
// PET 2001 datasette emulator: replays TAP pulse lengths onto cass_read at ce rate.
// Define PET2001_TAP_V1_EN to decode version-1 zero bytes as 24-bit pulse lengths.
module pet2001_tap_player
    import pet2001_tap_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 play,
    input  logic                 tap_version,
    pet2001_tap_player_if.slave  tap,
    input  logic                 cass_motor_n,
    output logic                 cass_read,
    output logic                 cass_sense_n,
    output logic                 underrun
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             cass_read_q, cass_read_d;
    logic             underrun_q, underrun_d;
    logic             started_q, started_d;
    logic             sense_q, sense_d;

    logic             fifo_flush;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             tick;
    logic             do_fetch;
    logic             start_pulse;
    logic [CNT_W-1:0] new_n;

`ifdef PET2001_TAP_V1_EN
    logic             ver_q, ver_d;
`else
    logic             unused_version;
    assign unused_version = tap_version;
`endif

    assign tap.tap_ready = reset_n && play && !fifo_full;
    assign tick          = ce && !cass_motor_n;
    assign cass_read     = cass_read_q;
    assign cass_sense_n  = sense_q;
    assign underrun      = underrun_q;

    pet2001_tap_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (tap.tap_valid && tap.tap_ready),
        .din     (tap.tap_data),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        cass_read_d = cass_read_q;
        underrun_d  = underrun_q;
        started_d   = started_q;
        sense_d     = !play;
        fifo_flush  = 1'b0;
        fifo_pop    = 1'b0;
        do_fetch    = 1'b0;
        start_pulse = 1'b0;
        new_n       = '0;
`ifdef PET2001_TAP_V1_EN
        ver_d = (state_q == ST_IDLE) ? tap_version : ver_q;
`endif
        if (!play) begin
            state_d     = ST_IDLE;
            cass_read_d = 1'b0;
            underrun_d  = 1'b0;
            started_d   = 1'b0;
            fifo_flush  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: do_fetch = tick;
                ST_HIGH: begin
                    if (tick) begin
                        if (cnt_q == '0) begin
                            state_d     = ST_LOW;
                            cass_read_d = 1'b0;
                            cnt_d       = n_q - (n_q >> 1) - CNT_ONE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                // The last LOW tick fetches directly so back-to-back pulses have no gap.
                ST_LOW: begin
                    if (tick) begin
                        if (cnt_q == '0) do_fetch = 1'b1;
                        else             cnt_d    = cnt_q - CNT_ONE;
                    end
                end
`ifdef PET2001_TAP_V1_EN
                ST_EXT0, ST_EXT1, ST_EXT2: begin
                    if (tick) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            case (state_q)
                                ST_EXT0: begin
                                    n_d[7:0] = fifo_dout;
                                    state_d  = ST_EXT1;
                                end
                                ST_EXT1: begin
                                    n_d[15:8] = fifo_dout;
                                    state_d   = ST_EXT2;
                                end
                                default: begin
                                    start_pulse = 1'b1;
                                    new_n = CNT_W'(clamp_pulse({fifo_dout, n_q[15:0]}));
                                end
                            endcase
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase

            if (do_fetch) begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    started_d = 1'b1;
                    if (fifo_dout != 8'h00) begin
                        start_pulse = 1'b1;
                        new_n       = CNT_W'(fifo_dout) * CNT_W'(PULSE_UNIT);
                    end
`ifdef PET2001_TAP_V1_EN
                    else if (ver_q) begin
                        state_d = ST_EXT0;
                        n_d     = '0;
                    end
`endif
                    else begin
                        start_pulse = 1'b1;
                        new_n       = CNT_W'(V0_OVERFLOW);
                    end
                end else begin
                    // Before the first byte the loader is still priming; that is not an underrun.
                    state_d = ST_FETCH;
                    if (started_q) underrun_d = 1'b1;
                end
            end

            if (start_pulse) begin
                state_d     = ST_HIGH;
                n_d         = new_n;
                cnt_d       = (new_n >> 1) - CNT_ONE;
                cass_read_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            cass_read_q <= 1'b0;
            underrun_q  <= 1'b0;
            started_q   <= 1'b0;
            sense_q     <= 1'b1;
`ifdef PET2001_TAP_V1_EN
            ver_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            cass_read_q <= cass_read_d;
            underrun_q  <= underrun_d;
            started_q   <= started_d;
            sense_q     <= sense_d;
`ifdef PET2001_TAP_V1_EN
            ver_q       <= ver_d;
`endif
        end
    end

endmodule
